// File: rtl/uart_pkg.sv
// Purpose: shared UART types and defaults for the RX and TX sides.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package uart_pkg;

   // Receiver FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Default frame geometry; instances normally override these.
   localparam int UART_DATA_W     = 32;
   localparam int UART_OVERSAMPLE = 16;

   // Counter width for a counter running 0..n-1. Never returns 0, so a
   // degenerate n still yields a legal vector.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_sipo_sync_2ff.sv
// Purpose: two-flop synchronizer that brings an asynchronous input into the clock domain.
// Latency: 2 clk_i cycles from d_i to q_o.
// Backpressure: none; it samples every cycle.
//
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; both flops load RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output
module sync_2ff #(
   parameter int                WIDTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// Purpose: oversampling UART receiver; assembles DATA_W bits LSB-first and presents the word.
// Latency: start edge at pin to Data_Valid = 2 + OVERSAMPLE/2 + (DATA_W+1)*OVERSAMPLE cycles.
// Backpressure: Data_Valid holds until Data_Ack; an unacked word is overwritten and Overrun pulses.
//
// Ports:
//   Baud_Clk   - sole clock, OVERSAMPLE x bit rate
//   Reset      - asynchronous active-low reset
//   Serial_In  - asynchronous serial line (idle = IDLE_LEVEL)
//   Data_Ack   - consumer accepts Data_Out while Data_Valid is high
//   Data_Out   - last good received word
//   Data_Valid - word available, held until acked
//   Frame_Err  - 1-cycle pulse when the stop bit is not IDLE_LEVEL
//   Overrun    - 1-cycle pulse when a good word replaces an unacked one
//   Busy       - FSM is outside IDLE
module uart_rx_sipo
   import uart_pkg::*;
#(
   parameter int   DATA_W     = UART_DATA_W,
   parameter int   OVERSAMPLE = UART_OVERSAMPLE,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              Baud_Clk,
   input  logic              Reset,
   input  logic              Serial_In,
   input  logic              Data_Ack,
   output logic [DATA_W-1:0] Data_Out,
   output logic              Data_Valid,
   output logic              Frame_Err,
   output logic              Overrun,
   output logic              Busy
);

   localparam int TICK_W = cnt_w(OVERSAMPLE);
   localparam int BIT_W  = cnt_w(DATA_W);

   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE/2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_END  = BIT_W'(DATA_W - 1);
   localparam logic              START_LEVEL = ~IDLE_LEVEL;

   // ---------------------------------------------------------------------
   // Input synchronizer; every decision below uses rx_s only.
   // ---------------------------------------------------------------------
   logic rx_s;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk_i  (Baud_Clk),
      .rst_ni (Reset),
      .d_i    (Serial_In),
      .q_o    (rx_s)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   rx_state_t         state_q, state_d;
   logic [TICK_W-1:0] tick_q,  tick_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] dout_q,  dout_d;
   logic              valid_q, valid_d;
   logic              ferr_q,  ferr_d;
   logic              ovr_q,   ovr_d;

   always_ff @(posedge Baud_Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   logic frame_good;

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      dout_d     = dout_q;
      valid_d    = valid_q;
      ferr_d     = 1'b0;
      ovr_d      = 1'b0;
      frame_good = 1'b0;

      unique case (state_q)
         IDLE: begin
            tick_d = '0;
            if (rx_s == START_LEVEL) begin
               state_d = START;
            end
         end

         START: begin
            // Re-check half a bit in: a short pulse is a glitch, not a start bit.
            if (tick_q == TICK_MID) begin
               tick_d = '0;
               if (rx_s == START_LEVEL) begin
                  state_d = DATA;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         DATA: begin
            // Ticks now count from mid-bit, so TICK_END lands mid-bit again.
            if (tick_q == TICK_END) begin
               tick_d  = '0;
               // New bit enters at the MSB; after DATA_W shifts bit 0 sits at the LSB.
               shreg_d = DATA_W'({rx_s, shreg_q} >> 1);
               if (bit_q == BIT_END) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         STOP: begin
            // Leave for IDLE at mid-stop so a back-to-back start bit is not missed.
            if (tick_q == TICK_END) begin
               tick_d  = '0;
               state_d = IDLE;
               if (rx_s == IDLE_LEVEL) begin
                  frame_good = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase

      // Output word handshake. An ack landing on the same edge as a new
      // word consumes the old word, so the new one is not an overrun.
      if (frame_good) begin
         dout_d  = shreg_q;
         valid_d = 1'b1;
         if (valid_q && !Data_Ack) begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && Data_Ack) begin
         valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign Data_Out   = dout_q;
   assign Data_Valid = valid_q;
   assign Frame_Err  = ferr_q;
   assign Overrun    = ovr_q;
   assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Purpose: self-checking bench for uart_rx_sipo (8-bit and 32-bit instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_sipo;

   localparam int OS = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_a, rx_b, ack_a, ack_b;
   logic [7:0]  dout_a;
   logic        valid_a, ferr_a, ovr_a, busy_a;
   logic [31:0] dout_b;
   logic        valid_b, ferr_b, ovr_b, busy_b;

   always #5 clk = ~clk;

   uart_rx_sipo #(.DATA_W(8), .OVERSAMPLE(OS), .IDLE_LEVEL(1'b0)) u_dut_a (
      .Baud_Clk   (clk),
      .Reset      (rst_n),
      .Serial_In  (rx_a),
      .Data_Ack   (ack_a),
      .Data_Out   (dout_a),
      .Data_Valid (valid_a),
      .Frame_Err  (ferr_a),
      .Overrun    (ovr_a),
      .Busy       (busy_a)
   );

   uart_rx_sipo #(.DATA_W(32), .OVERSAMPLE(OS), .IDLE_LEVEL(1'b0)) u_dut_b (
      .Baud_Clk   (clk),
      .Reset      (rst_n),
      .Serial_In  (rx_b),
      .Data_Ack   (ack_b),
      .Data_Out   (dout_b),
      .Data_Valid (valid_b),
      .Frame_Err  (ferr_b),
      .Overrun    (ovr_b),
      .Busy       (busy_b)
   );

   int checks   = 0;
   int failures = 0;
   int ferr_cnt_a = 0, ovr_cnt_a = 0, ferr_wide_a = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      bit         ack;
      logic [7:0] exp_dout;
      logic       exp_valid;
      int         exp_ferr;
      int         exp_ovr;
   } vec_t;

   vec_t vecs[6];

   int f0, o0, lat, busy_cnt;
   bit seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Counts pulses and pops the scoreboard whenever DUT A presents a new word.
   task automatic monitor();
      logic       v_prev = 1'b0;
      logic       f_prev = 1'b0;
      logic [7:0] e;
      forever begin
         @(posedge clk); #1;
         if (ferr_a) ferr_cnt_a++;
         if (ferr_a && f_prev) ferr_wide_a++;
         if (ovr_a) ovr_cnt_a++;
         if (ferr_b) ferr_cnt_b++;
         if (ovr_b) ovr_cnt_b++;
         if ((valid_a && !v_prev) || ovr_a) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: word 0x%0h with none expected", dout_a);
            end else begin
               e = exp_q.pop_front();
               check("sb_word", 32'(dout_a), 32'(e));
            end
         end
         v_prev = valid_a;
         f_prev = ferr_a;
      end
   endtask

   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_a(input logic [7:0] d, input logic stop, input bit push, input int gap);
      if (push) exp_q.push_back(d);
      drive(1'b0, 1'b1, OS);
      for (int i = 0; i < 8; i++) drive(1'b0, d[i], OS);
      drive(1'b0, stop, OS);
      drive(1'b0, 1'b0, gap);
   endtask

   // The first six bit cells are stretched/shrunk by skew, so bits 6..33
   // are displaced by 6*skew cycles from their nominal position.
   task automatic send_b(input logic [31:0] d, input int skew);
      int   len;
      logic v;
      for (int k = 0; k < 34; k++) begin
         len = OS + ((k < 6) ? skew : 0);
         if (k == 0)       v = 1'b1;
         else if (k == 33) v = 1'b0;
         else              v = d[k-1];
         drive(1'b1, v, len);
      end
      drive(1'b1, 1'b0, 2*OS);
   endtask

   task automatic ack_a_pulse(input string name);
      @(negedge clk) ack_a = 1'b1;
      @(posedge clk) #1;
      check(name, 32'(valid_a), 32'h0);
      @(negedge clk) ack_a = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rx_a  = 1'b0;
      rx_b  = 1'b0;
      ack_a = 1'b0;
      ack_b = 1'b0;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 0};
      vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 0, 0};
      vecs[3] = '{8'h3C, 1'b1, 1'b0, 8'hFF, 1'b1, 1, 0};
      vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 0, 1};
      vecs[5] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 0, 0};

      fork
         monitor();
      join_none

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_dout",  32'(dout_a),  32'h0);
      check("rst_valid", 32'(valid_a), 32'h0);
      check("rst_ferr",  32'(ferr_a),  32'h0);
      check("rst_ovr",   32'(ovr_a),   32'h0);
      check("rst_busy",  32'(busy_a),  32'h0);
      check("rst_dout_b", dout_b, 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Latency from the first edge that sees the start bit to Data_Valid.
      fork
         send_a(8'hA5, 1'b0, 1'b1, OS);
         begin
            lat  = 0;
            seen = 1'b0;
            @(posedge clk);
            for (int c = 0; c < 400 && !seen; c++) begin
               @(posedge clk); #1;
               lat++;
               if (valid_a) seen = 1'b1;
            end
            if (!seen) begin
               checks++;
               failures++;
               $display("FAIL lat_timeout: Data_Valid never rose, required 154 cycles");
            end else begin
               check("latency", 32'(lat), 32'd154);
            end
         end
      join
      check("lat_dout", 32'(dout_a), 32'hA5);
      ack_a_pulse("ack_clears_valid");

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         f0 = ferr_cnt_a;
         o0 = ovr_cnt_a;
         send_a(vecs[i].data, vecs[i].stop, vecs[i].stop == 1'b0, OS);
         check($sformatf("vec%0d_dout", i),  32'(dout_a), 32'(vecs[i].exp_dout));
         check($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_ferr", i),  32'(ferr_cnt_a - f0), 32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_ovr", i),   32'(ovr_cnt_a - o0),  32'(vecs[i].exp_ovr));
         if (vecs[i].ack) ack_a_pulse($sformatf("vec%0d_ack", i));
      end

      // Start-bit glitch 5 cycles wide.
      f0 = ferr_cnt_a;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk) rx_a = (i < 5);
         @(posedge clk) #1;
         if (busy_a) busy_cnt++;
      end
      check("glitch_busy_seen", 32'(busy_cnt > 0), 32'h1);
      check("glitch_busy_max",  32'(busy_cnt <= 10), 32'h1);
      check("glitch_valid",     32'(valid_a), 32'h0);
      check("glitch_ferr",      32'(ferr_cnt_a - f0), 32'h0);
      check("glitch_idle",      32'(busy_a), 32'h0);

      // Back-to-back frames, no ack.
      @(negedge clk);
      f0 = ferr_cnt_a;
      o0 = ovr_cnt_a;
      send_a(8'h11, 1'b0, 1'b1, 0);
      send_a(8'h22, 1'b0, 1'b1, OS);
      check("b2b_dout",  32'(dout_a), 32'h22);
      check("b2b_valid", 32'(valid_a), 32'h1);
      check("b2b_ovr",   32'(ovr_cnt_a - o0), 32'h1);
      check("b2b_ferr",  32'(ferr_cnt_a - f0), 32'h0);

      // Reset in the middle of data bit 4; held until the frame has passed.
      f0 = ferr_cnt_a;
      o0 = ovr_cnt_a;
      fork
         send_a(8'hC3, 1'b0, 1'b0, OS);
         begin
            repeat (OS + 4*OS + OS/2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("mid_rst_dout",  32'(dout_a),  32'h0);
            check("mid_rst_valid", 32'(valid_a), 32'h0);
            check("mid_rst_busy",  32'(busy_a),  32'h0);
            check("mid_rst_ferr",  32'(ferr_a),  32'h0);
            check("mid_rst_ovr",   32'(ovr_a),   32'h0);
         end
      join
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_rst_no_pulses", 32'((ferr_cnt_a - f0) + (ovr_cnt_a - o0)), 32'h0);
      send_a(8'h5A, 1'b0, 1'b1, OS);
      check("post_rst_dout",  32'(dout_a), 32'h5A);
      check("post_rst_valid", 32'(valid_a), 32'h1);
      ack_a_pulse("post_rst_ack");

      // 32-bit instance with +/-6 cycles of cumulative skew.
      for (int s = 0; s < 2; s++) begin
         f0 = ferr_cnt_b;
         send_b(32'hDEADBEEF, (s == 0) ? 1 : -1);
         check($sformatf("skew%0d_dout", s),  dout_b, 32'hDEADBEEF);
         check($sformatf("skew%0d_valid", s), 32'(valid_b), 32'h1);
         check($sformatf("skew%0d_ferr", s),  32'(ferr_cnt_b - f0), 32'h0);
         @(negedge clk) ack_b = 1'b1;
         @(posedge clk) #1;
         check($sformatf("skew%0d_ack", s), 32'(valid_b), 32'h0);
         @(negedge clk) ack_b = 1'b0;
      end
      check("skew_no_ovr", 32'(ovr_cnt_b), 32'h0);

      repeat (4) @(negedge clk);
      check("sb_drained",      32'(exp_q.size()), 32'h0);
      check("ferr_pulse_wide", 32'(ferr_wide_a), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
